fisc_fetch_unit: RTL and testbench
==================================

// Module: fisc_fetch_unit
// PURPOSE
//  Parametrised instruction fetch unit for the FISC core; replaces the core's inline FETCH1/FETCH2 states.
//  Reads WORD_W-bit memory words over a req/ack port and splits each word into WORD_W/INSN_W instructions,
//  lowest slice first. Buffers them in a QDEPTH-entry prefetch queue with a valid/ready interface toward decode.
//  Supports PC redirect (branch/IRQ) with queue flush and discard of in-flight responses.
// PARAMETERS
//  WORD_W    64  memory word width (bits); WORD_W/INSN_W = IPW, must be a power of 2, >= 1
//  INSN_W    32  instruction width (bits)
//  PC_W      64  byte-address PC width
//  MADDR_W   32  memory word-address width
//  QDEPTH    4   prefetch queue depth in instructions; power of 2, >= IPW
//  PC_RESET  0   PC loaded at reset
// PORTS
//  clk           in   1        clock
//  reset_n       in   1        synchronous reset, active-low
//  mem_rd        out  1        read request; held high until mem_ack
//  mem_addr      out  MADDR_W  word address = pc >> log2(WORD_W/8); stable while mem_rd=1
//  mem_ack       in   1        one-cycle pulse: mem_rdata valid, request complete
//  mem_rdata     in   WORD_W   returned memory word
//  insn_valid    out  1        queue head valid
//  insn          out  INSN_W   queue head instruction
//  insn_pc       out  PC_W     byte PC of queue head
//  insn_ready    in   1        decode accepts head (transfer = insn_valid & insn_ready)
//  redirect_en   in   1        one-cycle pulse: flush and restart at redirect_pc
//  redirect_pc   in   PC_W     target PC; must be INSN_W/8 aligned
//  fetch_busy    out  1        request outstanding (FSM in S_REQ or S_DROP)
// BEHAVIOUR
//  Reset: mem_rd=0, mem_addr=0, insn_valid=0, insn=0, insn_pc=0, fetch_busy=0; queue empty; fetch pc=PC_RESET; FSM S_IDLE.
//  Reset has priority over all inputs; mem_ack arriving during/after reset for a pre-reset request is ignored.
//  FSM: S_IDLE - mem_rd=0; go S_REQ when free=QDEPTH-count >= IPW (free evaluated after this cycle's pop).
//       S_REQ  - mem_rd=1, mem_addr=pc word address; on mem_ack: push slices slot..IPW-1,
//                slot = pc[log2(WORD_W/8)-1:log2(INSN_W/8)], each with pc of its slice; pc <= next word base;
//                then S_REQ if free >= IPW else S_IDLE.
//       S_DROP - mem_rd=1 (same address as before); on mem_ack: discard data, go S_REQ with current pc.
//  Redirect (highest priority after reset): queue cleared, pc <= redirect_pc.
//    in S_IDLE -> S_REQ; in S_REQ w/o ack -> S_DROP; in S_REQ with ack same cycle -> data discarded, S_REQ;
//    in S_DROP -> stay (ack same cycle: -> S_REQ). A pop in the redirect cycle is a completed transfer.
//  Queue: circular, count 0..QDEPTH, simultaneous push (up to IPW) and pop allowed; never overflows by construction.
//  Latency: reset release -> mem_rd=1 next cycle; mem_ack in cycle N -> insn_valid=1 in N+1 (empty queue);
//    redirect in cycle N -> mem_rd with new address in N+1 unless S_DROP pending.
//  insn/insn_pc hold last head value when insn_valid=0; no combinational path mem_ack->insn_valid.
//  PC wraps modulo 2^PC_W; mem_addr truncated to MADDR_W.
// TESTING (WORD_W=64, INSN_W=32, QDEPTH=4)
//  Reset, ack addr 0 with 0x22222222_11111111 -> insn 0x11111111 pc 0, then 0x22222222 pc 4; next mem_addr=1.
//  Redirect to 0x0C, ack 0xBBBBBBBB_AAAAAAAA -> mem_addr=1, only 0xBBBBBBBB pc 0x0C queued; next mem_addr=2.
//  insn_ready=0, acks immediate -> 2 words queued, count=4, mem_rd=0; one pop -> still idle; second pop -> mem_rd=1.
//  Redirect to 0x40 while ack delayed 3 cycles -> returned word dropped, insn_valid stays 0, then mem_addr=8.
//  Redirect, mem_ack and pop same cycle -> popped insn counted, ack data discarded, queue empty, next mem_addr=redirect.
//  reset_n low in S_REQ with ack pending -> mem_rd=0 next cycle, queue empty, restart at mem_addr=PC_RESET>>3.

Source files
------------

// File: rtl/fisc_fetch_if.sv
// Fetch unit bus bundle: memory read port, decode-side valid/ready head and redirect input.
interface fisc_fetch_if #(
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned INSN_W  = 32,
  parameter int unsigned PC_W    = 64,
  parameter int unsigned MADDR_W = 32
);
  logic               mem_rd;
  logic [MADDR_W-1:0] mem_addr;
  logic               mem_ack;
  logic [WORD_W-1:0]  mem_rdata;
  logic               insn_valid;
  logic [INSN_W-1:0]  insn;
  logic [PC_W-1:0]    insn_pc;
  logic               insn_ready;
  logic               redirect_en;
  logic [PC_W-1:0]    redirect_pc;
  logic               fetch_busy;

  modport master (
    output mem_rd, mem_addr, insn_valid, insn, insn_pc, fetch_busy,
    input  mem_ack, mem_rdata, insn_ready, redirect_en, redirect_pc
  );

  modport slave (
    input  mem_rd, mem_addr, insn_valid, insn, insn_pc, fetch_busy,
    output mem_ack, mem_rdata, insn_ready, redirect_en, redirect_pc
  );
endinterface

// File: rtl/fisc_fetch_unit.sv
// Instruction fetch unit: reads memory words, splits them into instructions and buffers them
// in a prefetch queue toward decode; redirect flushes the queue and discards in-flight data.
module fisc_fetch_unit #(
  parameter int unsigned    WORD_W   = 64,
  parameter int unsigned    INSN_W   = 32,
  parameter int unsigned    PC_W     = 64,
  parameter int unsigned    MADDR_W  = 32,
  parameter int unsigned    QDEPTH   = 4,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  fisc_fetch_if.master bus_io
);
  localparam int unsigned IPW   = WORD_W / INSN_W;
  localparam int unsigned WB    = WORD_W / 8;
  localparam int unsigned IB    = INSN_W / 8;
  localparam int unsigned OFF_W = $clog2(WB);
  localparam int unsigned ISH   = $clog2(IB);
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [MADDR_W-1:0] addr_q, addr_d;
  logic [INSN_W-1:0]  qinsn_q [QDEPTH];
  logic [INSN_W-1:0]  qinsn_d [QDEPTH];
  logic [PC_W-1:0]    qpc_q [QDEPTH];
  logic [PC_W-1:0]    qpc_d [QDEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSN_W-1:0]  last_insn_q;
  logic [PC_W-1:0]    last_pc_q;

  logic            pop;
  logic [PC_W-1:0] word_base;
  int unsigned     slot, n_push, free_pop, cnt_after;

  assign pop       = (cnt_q != '0) && bus_io.insn_ready;
  assign word_base = pc_q & ~PC_W'(WB - 1);
  assign slot      = int'((pc_q & PC_W'(WB - 1)) >> ISH);

  always_comb begin : next_state
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    qinsn_d   = qinsn_q;
    qpc_d     = qpc_q;
    rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    n_push    = 0;
    free_pop  = QDEPTH - int'(cnt_q) + (pop ? 1 : 0);
    cnt_after = 0;

    if (bus_io.redirect_en) begin
      // Flush: any response arriving now or later for the old pc is thrown away.
      pc_d     = bus_io.redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      unique case (state_q)
        StIdle:  state_d = StReq;
        StReq:   state_d = bus_io.mem_ack ? StReq : StDrop;
        StDrop:  state_d = bus_io.mem_ack ? StReq : StDrop;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: if (free_pop >= IPW) state_d = StReq;
        StReq: begin
          if (bus_io.mem_ack) begin
            for (int unsigned i = 0; i < IPW; i++) begin
              if (i >= slot) begin : push_slice
                int unsigned idx;
                idx        = (int'(wr_ptr_q) + i - slot) % QDEPTH;
                qinsn_d[idx] = bus_io.mem_rdata[i*INSN_W +: INSN_W];
                qpc_d[idx]   = word_base + PC_W'(i * IB);
              end
            end
            n_push    = IPW - slot;
            wr_ptr_d  = wr_ptr_q + PTR_W'(n_push);
            pc_d      = word_base + PC_W'(WB);
            cnt_after = int'(cnt_q) + n_push - (pop ? 1 : 0);
            state_d   = (QDEPTH - cnt_after >= IPW) ? StReq : StIdle;
          end
        end
        StDrop:  if (bus_io.mem_ack) state_d = StReq;
        default: state_d = StIdle;
      endcase
    end

    cnt_d = bus_io.redirect_en ? '0 : CNT_W'(int'(cnt_q) + n_push - (pop ? 1 : 0));
    // Address is latched on entry to StReq so it stays put through a drop.
    if (state_d == StReq) addr_d = MADDR_W'(pc_d >> OFF_W);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pc_q        <= PC_RESET;
      addr_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      last_insn_q <= '0;
      last_pc_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qinsn_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      qinsn_q  <= qinsn_d;
      qpc_q    <= qpc_d;
      if (cnt_q != '0) begin
        last_insn_q <= qinsn_q[rd_ptr_q];
        last_pc_q   <= qpc_q[rd_ptr_q];
      end
    end
  end

  assign bus_io.mem_rd     = (state_q != StIdle);
  assign bus_io.fetch_busy = (state_q != StIdle);
  assign bus_io.mem_addr   = addr_q;
  assign bus_io.insn_valid = (cnt_q != '0);
  assign bus_io.insn       = (cnt_q != '0) ? qinsn_q[rd_ptr_q] : last_insn_q;
  assign bus_io.insn_pc    = (cnt_q != '0) ? qpc_q[rd_ptr_q] : last_pc_q;
endmodule

// File: tb/tb_fisc_fetch_unit.sv
// Directed bench for fisc_fetch_unit with WORD_W=64, INSN_W=32, QDEPTH=4, PC_RESET=0.
module tb_fisc_fetch_unit;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  fisc_fetch_if #(.WORD_W(64), .INSN_W(32), .PC_W(64), .MADDR_W(32)) bus ();

  fisc_fetch_unit #(
    .WORD_W(64), .INSN_W(32), .PC_W(64), .MADDR_W(32), .QDEPTH(4), .PC_RESET(64'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_word(input logic [63:0] data);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.insn_ready = 1'b0;
    bus.redirect_en = 1'b0; bus.redirect_pc = '0;
    tick(); tick();
    checks++; if (bus.mem_rd !== 1'b0) begin errors++;
      $display("FAIL rst_mem_rd: got %0h want 0", bus.mem_rd); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++;
      $display("FAIL rst_mem_addr: got %0h want 0", bus.mem_addr); end
    checks++; if ({bus.insn_valid, bus.fetch_busy} !== 2'b00) begin errors++;
      $display("FAIL rst_valid_busy: got %0b want 00", {bus.insn_valid, bus.fetch_busy}); end
    checks++; if ({bus.insn, bus.insn_pc} !== 96'h0) begin errors++;
      $display("FAIL rst_insn: got %0h want 0", {bus.insn, bus.insn_pc}); end
    reset_n = 1'b1;
    tick();
    checks++; if ({bus.mem_rd, bus.fetch_busy} !== 2'b11 || bus.mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_release_req: got rd=%0b addr=%0h want rd=1 addr=0",
                         bus.mem_rd, bus.mem_addr); end
  endtask

  task automatic test_basic();
    ack_word(64'h22222222_11111111);
    checks++; if (bus.insn_valid !== 1'b1 || bus.insn !== 32'h11111111 || bus.insn_pc !== 64'h0)
    begin errors++; $display("FAIL basic_head0: got v=%0b %0h@%0h want 1 11111111@0",
                             bus.insn_valid, bus.insn, bus.insn_pc); end
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h1) begin errors++;
      $display("FAIL basic_next_addr: got rd=%0b addr=%0h want 1/1", bus.mem_rd, bus.mem_addr); end
    bus.insn_ready = 1'b1;
    tick();
    checks++; if (bus.insn_valid !== 1'b1 || bus.insn !== 32'h22222222 || bus.insn_pc !== 64'h4)
    begin errors++; $display("FAIL basic_head1: got v=%0b %0h@%0h want 1 22222222@4",
                             bus.insn_valid, bus.insn, bus.insn_pc); end
    tick();
    bus.insn_ready = 1'b0;
    checks++; if (bus.insn_valid !== 1'b0 || bus.insn !== 32'h22222222 || bus.insn_pc !== 64'h4)
    begin errors++; $display("FAIL basic_hold: got v=%0b %0h@%0h want 0 22222222@4",
                             bus.insn_valid, bus.insn, bus.insn_pc); end
  endtask

  task automatic test_redirect_unaligned();
    bus.redirect_en = 1'b1; bus.redirect_pc = 64'h0C;
    tick();
    bus.redirect_en = 1'b0;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h1) begin errors++;
      $display("FAIL unal_drop_addr: got rd=%0b addr=%0h want 1/1", bus.mem_rd, bus.mem_addr); end
    ack_word(64'hDEADDEAD_DEADDEAD);
    checks++; if (bus.insn_valid !== 1'b0 || bus.mem_addr !== 32'h1) begin errors++;
      $display("FAIL unal_dropped: got v=%0b addr=%0h want 0/1", bus.insn_valid, bus.mem_addr); end
    ack_word(64'hBBBBBBBB_AAAAAAAA);
    checks++; if (bus.insn_valid !== 1'b1 || bus.insn !== 32'hBBBBBBBB || bus.insn_pc !== 64'hC)
    begin errors++; $display("FAIL unal_head: got v=%0b %0h@%0h want 1 BBBBBBBB@C",
                             bus.insn_valid, bus.insn, bus.insn_pc); end
    checks++; if (bus.mem_addr !== 32'h2) begin errors++;
      $display("FAIL unal_next_addr: got %0h want 2", bus.mem_addr); end
    bus.insn_ready = 1'b1;
    tick();
    bus.insn_ready = 1'b0;
    checks++; if (bus.insn_valid !== 1'b0) begin errors++;
      $display("FAIL unal_single: got v=%0b want 0", bus.insn_valid); end
  endtask

  task automatic test_queue_full();
    ack_word(64'h44444444_33333333);
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h3) begin errors++;
      $display("FAIL full_half: got rd=%0b addr=%0h want 1/3", bus.mem_rd, bus.mem_addr); end
    ack_word(64'h66666666_55555555);
    checks++; if (bus.mem_rd !== 1'b0 || bus.fetch_busy !== 1'b0) begin errors++;
      $display("FAIL full_idle: got rd=%0b busy=%0b want 0/0", bus.mem_rd, bus.fetch_busy); end
    checks++; if (bus.insn !== 32'h33333333 || bus.insn_pc !== 64'h10) begin errors++;
      $display("FAIL full_head: got %0h@%0h want 33333333@10", bus.insn, bus.insn_pc); end
    bus.insn_ready = 1'b1; tick(); bus.insn_ready = 1'b0;
    checks++; if (bus.mem_rd !== 1'b0 || bus.insn !== 32'h44444444 || bus.insn_pc !== 64'h14)
    begin errors++; $display("FAIL full_pop1: got rd=%0b %0h@%0h want 0 44444444@14",
                             bus.mem_rd, bus.insn, bus.insn_pc); end
    bus.insn_ready = 1'b1; tick(); bus.insn_ready = 1'b0;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h4) begin errors++;
      $display("FAIL full_pop2_req: got rd=%0b addr=%0h want 1/4", bus.mem_rd, bus.mem_addr); end
    checks++; if (bus.insn !== 32'h55555555 || bus.insn_pc !== 64'h18) begin errors++;
      $display("FAIL full_pop2_head: got %0h@%0h want 55555555@18", bus.insn, bus.insn_pc); end
    bus.insn_ready = 1'b1; tick(); tick(); bus.insn_ready = 1'b0;
    checks++; if (bus.insn_valid !== 1'b0 || bus.insn !== 32'h66666666) begin errors++;
      $display("FAIL full_drain: got v=%0b %0h want 0 66666666", bus.insn_valid, bus.insn); end
  endtask

  task automatic test_redirect_drop();
    bus.redirect_en = 1'b1; bus.redirect_pc = 64'h40;
    tick();
    bus.redirect_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h4 || bus.insn_valid !== 1'b0)
      begin errors++; $display("FAIL drop_wait%0d: got rd=%0b addr=%0h v=%0b want 1/4/0",
                               i, bus.mem_rd, bus.mem_addr, bus.insn_valid); end
      tick();
    end
    ack_word(64'hCAFECAFE_CAFECAFE);
    checks++; if (bus.insn_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h8)
    begin errors++; $display("FAIL drop_restart: got v=%0b rd=%0b addr=%0h want 0/1/8",
                             bus.insn_valid, bus.mem_rd, bus.mem_addr); end
  endtask

  task automatic test_back_to_back();
    ack_word(64'h88888888_77777777);
    checks++; if (bus.insn !== 32'h77777777 || bus.insn_pc !== 64'h40 || bus.mem_addr !== 32'h9)
    begin errors++; $display("FAIL b2b_head: got %0h@%0h addr=%0h want 77777777@40 addr=9",
                             bus.insn, bus.insn_pc, bus.mem_addr); end
    bus.redirect_en = 1'b1; bus.redirect_pc = 64'h100; bus.insn_ready = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'hEEEEEEEE_EEEEEEEE;
    tick();
    bus.redirect_en = 1'b0; bus.insn_ready = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    checks++; if (bus.insn_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_flush: got v=%0b want 0", bus.insn_valid); end
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h20) begin errors++;
      $display("FAIL b2b_addr: got rd=%0b addr=%0h want 1/20", bus.mem_rd, bus.mem_addr); end
  endtask

  task automatic test_reset_midreq();
    ack_word(64'hA5A5A5A5_5A5A5A5A);
    reset_n = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 64'h0BAD0BAD_0BAD0BAD;
    tick();
    checks++; if ({bus.mem_rd, bus.insn_valid, bus.fetch_busy} !== 3'b000) begin errors++;
      $display("FAIL mid_rst: got rd/v/busy=%0b want 000",
               {bus.mem_rd, bus.insn_valid, bus.fetch_busy}); end
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; reset_n = 1'b1;
    checks++; if (bus.insn_valid !== 1'b0 || bus.mem_addr !== 32'h0) begin errors++;
      $display("FAIL mid_rst_hold: got v=%0b addr=%0h want 0/0", bus.insn_valid, bus.mem_addr); end
    tick();
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h0 || bus.insn_valid !== 1'b0)
    begin errors++; $display("FAIL mid_restart: got rd=%0b addr=%0h v=%0b want 1/0/0",
                             bus.mem_rd, bus.mem_addr, bus.insn_valid); end
    ack_word(64'h12345678_9ABCDEF0);
    checks++; if (bus.insn !== 32'h9ABCDEF0 || bus.insn_pc !== 64'h0) begin errors++;
      $display("FAIL mid_first: got %0h@%0h want 9ABCDEF0@0", bus.insn, bus.insn_pc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_redirect_unaligned();
    test_queue_full();
    test_redirect_drop();
    test_back_to_back();
    test_reset_midreq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
